// File: rtl/apb_image_loader.sv
// APB slave front-end for the visible-watermarking core.
// Holds the watermark parameter registers plus the primary and watermark
// image buffers, issues a one-cycle start pulse and locks the buffers while
// the core runs. Write errors are sticky in the status word.
// Optional build macro: APB_LOADER_PSLVERR_EN adds a PSLVERR output.
module apb_image_loader #(
  parameter int Amba_Word        = 16,
  parameter int Amba_Addr_Depth  = 20,
  parameter int Data_Depth       = 8,
  parameter int Channels         = 1,
  parameter int Max_Image_Pixels = 16384,
  parameter int Pix_Addr_W       = 14
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             PENABLE,
  input  logic                             PSEL,
  input  logic                             PWRITE,
  input  logic [Amba_Addr_Depth:0]         PADDR,
  input  logic [Amba_Word-1:0]             PWDATA,
  output logic [Amba_Word-1:0]             PRDATA,
  input  logic                             Image_Done,
  output logic                             start_work,
  output logic                             busy,
  output logic [Data_Depth-1:0]            Iwhite,
  output logic [Data_Depth-1:0]            Np,
  output logic [Data_Depth-1:0]            Nw,
  output logic [Data_Depth-1:0]            M,
  output logic [Data_Depth-1:0]            Bthr,
  output logic [Data_Depth-1:0]            Amin,
  output logic [Data_Depth-1:0]            Amax,
  output logic [Data_Depth-1:0]            Bmin,
  output logic [Data_Depth-1:0]            Bmax,
  input  logic                             rd_sel,
  input  logic [Pix_Addr_W-1:0]            rd_addr,
  output logic [Channels*Data_Depth-1:0]   rd_data
`ifdef APB_LOADER_PSLVERR_EN
  ,
  output logic                             PSLVERR
`endif
);

  localparam int AW = Amba_Addr_Depth + 1;
  localparam int PW = Channels * Data_Depth;
  localparam int SW = 2 * Data_Depth;

  typedef logic [AW-1:0] addr_t;

  logic [Data_Depth-1:0] par_q [9];
  logic [PW-1:0]         prim_mem [Max_Image_Pixels];
  logic [PW-1:0]         wm_mem   [Max_Image_Pixels];

  logic busy_q, busy_d, start_q, start_d, err_q, err_d;
  logic pdone_q, pdone_d, wdone_q, wdone_d;
  logic [Amba_Word-1:0] prdata_q, prdata_d;
  logic [PW-1:0]        rdd_q, rdd_d;

  logic [SW-1:0]         np_sq, nw_sq;
  addr_t                 wb, wm_end, prim_idx, wm_idx, pix_idx;
  logic [Pix_Addr_W-1:0] pix_a;
  logic [3:0]            par_sel;
  logic wr_en, rd_setup, is_ctrl, is_par, is_prim, is_wm, idx_ok;
  logic par_we, prim_we, wm_we, n_wr, err_wr, ctl_we, start_ok, start_ref, clr_err;
  logic unused_ok;

  function automatic logic [Amba_Word-1:0] zext_pix(input logic [PW-1:0] v);
    zext_pix = '0;
    zext_pix[PW-1:0] = v;
  endfunction

  function automatic logic [Amba_Word-1:0] zext_par(input logic [Data_Depth-1:0] v);
    zext_par = '0;
    zext_par[Data_Depth-1:0] = v;
  endfunction

  // Address decode: image sizes are squared at 2*Data_Depth bits, the
  // watermark window floats directly behind the primary window.
  assign wr_en    = PSEL & PENABLE & PWRITE;
  assign rd_setup = PSEL & ~PENABLE & ~PWRITE;
  assign np_sq    = SW'(par_q[1]) * SW'(par_q[1]);
  assign nw_sq    = SW'(par_q[2]) * SW'(par_q[2]);
  assign wb       = addr_t'(10) + addr_t'(np_sq);
  assign wm_end   = wb + addr_t'(nw_sq);
  assign is_ctrl  = (PADDR == '0);
  assign is_par   = (PADDR >= addr_t'(1)) && (PADDR <= addr_t'(9));
  assign is_prim  = (PADDR >= addr_t'(10)) && (PADDR < wb);
  assign is_wm    = (PADDR >= wb) && (PADDR < wm_end);
  assign prim_idx = PADDR - addr_t'(10);
  assign wm_idx   = PADDR - wb;
  assign pix_idx  = is_prim ? prim_idx : wm_idx;
  assign idx_ok   = (pix_idx < addr_t'(Max_Image_Pixels));
  assign pix_a    = pix_idx[Pix_Addr_W-1:0];
  assign par_sel  = PADDR[3:0] - 4'd1;

  // Write classification: everything except control is refused while busy.
  assign par_we    = wr_en & is_par & ~busy_q;
  assign prim_we   = wr_en & is_prim & idx_ok & ~busy_q;
  assign wm_we     = wr_en & is_wm & idx_ok & ~busy_q;
  assign n_wr      = par_we & ((PADDR == addr_t'(2)) || (PADDR == addr_t'(3)));
  assign err_wr    = wr_en & ~is_ctrl &
                     (busy_q | ~(is_par | is_prim | is_wm) | ((is_prim | is_wm) & ~idx_ok));
  assign ctl_we    = wr_en & is_ctrl;
  assign start_ok  = ctl_we & PWDATA[0] & ~busy_q & pdone_q & wdone_q;
  assign start_ref = ctl_we & PWDATA[0] & ~start_ok;
  assign clr_err   = ctl_we & PWDATA[1];
  assign unused_ok = ^PWDATA;

`ifdef APB_LOADER_PSLVERR_EN
  assign PSLVERR = err_wr | start_ref;
`endif

  // Control next-state: start wins the cycle, clear-error is applied last.
  always_comb begin
    start_d = start_ok;
    busy_d  = busy_q;
    if (start_ok) busy_d = 1'b1;
    else if (busy_q && Image_Done) busy_d = 1'b0;
    err_d = err_q | err_wr | start_ref;
    if (clr_err) err_d = 1'b0;
    pdone_d = pdone_q;
    wdone_d = wdone_q;
    if (n_wr) begin
      pdone_d = 1'b0;
      wdone_d = 1'b0;
    end
    if (prim_we && (prim_idx == addr_t'(np_sq) - addr_t'(1))) pdone_d = 1'b1;
    if (wm_we && (wm_idx == addr_t'(nw_sq) - addr_t'(1)))     wdone_d = 1'b1;
  end

  // APB read data is captured in the setup phase and held otherwise.
  always_comb begin
    prdata_d = prdata_q;
    if (rd_setup) begin
      prdata_d = '0;
      if (is_ctrl) prdata_d[3:0] = {wdone_q, pdone_q, err_q, busy_q};
      else if (is_par) prdata_d = zext_par(par_q[par_sel]);
      else if ((is_prim || is_wm) && idx_ok)
        prdata_d = zext_pix(is_prim ? prim_mem[pix_a] : wm_mem[pix_a]);
    end
  end

  // Core read port; out-of-range indices read as zero.
  always_comb begin
    rdd_d = '0;
    if (32'(rd_addr) < 32'(Max_Image_Pixels))
      rdd_d = rd_sel ? wm_mem[rd_addr] : prim_mem[rd_addr];
  end

  // Control, status and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      pdone_q  <= 1'b0;
      wdone_q  <= 1'b0;
      prdata_q <= '0;
      rdd_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      start_q  <= start_d;
      err_q    <= err_d;
      pdone_q  <= pdone_d;
      wdone_q  <= wdone_d;
      prdata_q <= prdata_d;
      rdd_q    <= rdd_d;
    end
  end

  // Parameter register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) par_q[i] <= '0;
    end else if (par_we) begin
      par_q[par_sel] <= PWDATA[Data_Depth-1:0];
    end
  end

  // Image buffers; contents are not reset.
  always_ff @(posedge clk) begin
    if (prim_we) prim_mem[pix_a] <= PWDATA[PW-1:0];
    if (wm_we)   wm_mem[pix_a]   <= PWDATA[PW-1:0];
  end

  assign PRDATA     = prdata_q;
  assign start_work = start_q;
  assign busy       = busy_q;
  assign rd_data    = rdd_q;
  assign Iwhite     = par_q[0];
  assign Np         = par_q[1];
  assign Nw         = par_q[2];
  assign M          = par_q[3];
  assign Bthr       = par_q[4];
  assign Amin       = par_q[5];
  assign Amax       = par_q[6];
  assign Bmin       = par_q[7];
  assign Bmax       = par_q[8];

endmodule

// File: tb/tb_apb_image_loader.sv
// Scoreboard bench for apb_image_loader. Two instances share the APB bus:
// dut1 with one channel per word, dut2 with two, so channel packing can be
// compared on identical traffic.
module tb_apb_image_loader;

  logic        clk = 1'b0;
  logic        rst, PENABLE, PSEL, PWRITE, Image_Done, rd_sel;
  logic [20:0] PADDR;
  logic [15:0] PWDATA;
  logic [13:0] rd_addr;
  logic [15:0] prdata1, prdata2;
  logic        sw1, sw2, busy1, busy2;
  logic [7:0]  p1 [9];
  logic [7:0]  p2 [9];
  logic [7:0]  rd1;
  logic [15:0] rd2;
`ifdef APB_LOADER_PSLVERR_EN
  logic        pslverr1, pslverr2;
`endif

  always #5 clk = ~clk;

  apb_image_loader #(.Channels(1)) dut1 (
    .clk(clk), .rst(rst), .PENABLE(PENABLE), .PSEL(PSEL), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata1), .Image_Done(Image_Done),
    .start_work(sw1), .busy(busy1),
    .Iwhite(p1[0]), .Np(p1[1]), .Nw(p1[2]), .M(p1[3]), .Bthr(p1[4]),
    .Amin(p1[5]), .Amax(p1[6]), .Bmin(p1[7]), .Bmax(p1[8]),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd1)
`ifdef APB_LOADER_PSLVERR_EN
    , .PSLVERR(pslverr1)
`endif
  );

  apb_image_loader #(.Channels(2)) dut2 (
    .clk(clk), .rst(rst), .PENABLE(PENABLE), .PSEL(PSEL), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata2), .Image_Done(Image_Done),
    .start_work(sw2), .busy(busy2),
    .Iwhite(p2[0]), .Np(p2[1]), .Nw(p2[2]), .M(p2[3]), .Bthr(p2[4]),
    .Amin(p2[5]), .Amax(p2[6]), .Bmin(p2[7]), .Bmax(p2[8]),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd2)
`ifdef APB_LOADER_PSLVERR_EN
    , .PSLVERR(pslverr2)
`endif
  );

  typedef struct {
    string       nm;
    logic [15:0] e1;
    logic [15:0] e2;
  } exp_t;

  exp_t apb_q[$];
  exp_t core_q[$];
  exp_t mon_e;
  int   vecs = 0;
  int   miss = 0;
  bit   rd_req = 1'b0;
  bit   core_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic apb_wr(input logic [20:0] a, input logic [15:0] d,
                        input bit done_acc = 1'b0, input bit rst_acc = 1'b0);
    @(posedge clk); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1; Image_Done = done_acc; rst = rst_acc;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; Image_Done = 1'b0; rst = 1'b0;
  endtask

  task automatic apb_rd(input logic [20:0] a, input logic [15:0] e1,
                        input logic [15:0] e2, input string nm);
    apb_q.push_back('{nm, e1, e2});
    @(posedge clk); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic core_rd(input logic sel, input logic [13:0] a, input logic [15:0] e1,
                         input logic [15:0] e2, input string nm);
    core_q.push_back('{nm, e1, e2});
    @(posedge clk); #1;
    rd_sel = sel; rd_addr = a; rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: pops an expectation whenever either output port presents data.
  always @(negedge clk) begin
    if (PSEL && PENABLE && !PWRITE) begin
      if (apb_q.size() == 0) begin
        chk("apb_unexpected_read", 32'(apb_q.size()), 32'd1);
      end else begin
        mon_e = apb_q.pop_front();
        chk({mon_e.nm, "_ch1"}, 32'(prdata1), 32'(mon_e.e1));
        chk({mon_e.nm, "_ch2"}, 32'(prdata2), 32'(mon_e.e2));
      end
    end
    if (core_pend) begin
      if (core_q.size() == 0) begin
        chk("core_unexpected_read", 32'(core_q.size()), 32'd1);
      end else begin
        mon_e = core_q.pop_front();
        chk({mon_e.nm, "_ch1"}, 32'(rd1), 32'(mon_e.e1));
        chk({mon_e.nm, "_ch2"}, 32'(rd2), 32'(mon_e.e2));
      end
    end
    core_pend = rd_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d", vecs);
    $fatal(1, "timeout");
  end

  logic [7:0] pv [9];

  initial begin
    pv = '{8'd200, 8'd4, 8'd4, 8'd3, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    Image_Done = 1'b0; rd_sel = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_work", 32'(sw1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_np", 32'(p1[1]), 32'd0);
    chk("rst_prdata", 32'(prdata1), 32'd0);
    chk("rst_rd_data", 32'(rd1), 32'd0);
    rst = 1'b0;
    apb_rd(21'd0, 16'h0, 16'h0, "status_after_reset");

    // Parameters: Iwhite=200, Np=4, Nw=4 -> 16+16 pixels, watermark base 26.
    for (int i = 0; i < 9; i++) apb_wr(21'(i + 1), {8'h00, pv[i]});
    chk("iwhite", 32'(p1[0]), 32'd200);
    chk("np", 32'(p1[1]), 32'd4);
    chk("bmax", 32'(p1[8]), 32'd9);
    apb_rd(21'd5, 16'd5, 16'd5, "read_bthr");

    // Only 15 primary pixels, full watermark: start refused, status = wm|err = 0xA.
    for (int i = 0; i < 15; i++) apb_wr(21'(10 + i), 16'(i));
    for (int i = 0; i < 16; i++) apb_wr(21'(26 + i), 16'(i));
    apb_wr(21'd0, 16'h1);
    chk("refused_start_work", 32'(sw1), 32'd0);
    chk("refused_busy", 32'(busy1), 32'd0);
    apb_rd(21'd0, 16'hA, 16'hA, "status_refused");

    // Clear error, finish primary image, start: one pulse, status 0xD.
    apb_wr(21'd0, 16'h2);
    apb_wr(21'd25, 16'd15);
    apb_rd(21'd0, 16'hC, 16'hC, "status_loaded");
    apb_wr(21'd0, 16'h1);
    chk("start_pulse", 32'(sw1), 32'd1);
    chk("start_busy", 32'(busy1), 32'd1);
    @(posedge clk); #1;
    chk("start_pulse_end", 32'(sw1), 32'd0);
    chk("busy_held", 32'(busy1), 32'd1);
    apb_rd(21'd0, 16'hD, 16'hD, "status_busy");
    core_rd(1'b1, 14'd3, 16'd3, 16'd3, "core_wm3");
    core_rd(1'b0, 14'd15, 16'd15, 16'd15, "core_prim15");
    apb_rd(21'd29, 16'd3, 16'd3, "read_wm3");

    // Locked buffers: Np write ignored, err set -> status 0xF.
    apb_wr(21'd2, 16'd9);
    chk("np_locked", 32'(p1[1]), 32'd4);
    apb_rd(21'd0, 16'hF, 16'hF, "status_locked_err");

    // Image_Done together with a start: start refused, busy drops.
    apb_wr(21'd0, 16'h1, 1'b1, 1'b0);
    chk("done_busy_clear", 32'(busy1), 32'd0);
    chk("done_no_pulse", 32'(sw1), 32'd0);
    apb_wr(21'd0, 16'h2);
    apb_rd(21'd0, 16'hC, 16'hC, "status_err_cleared");

    // Channel packing: 0xA55A truncates to 0x5A with one channel.
    apb_wr(21'd10, 16'hA55A);
    apb_rd(21'd10, 16'h005A, 16'hA55A, "read_prim0_packed");
    core_rd(1'b0, 14'd0, 16'h005A, 16'hA55A, "core_prim0_packed");

    // Unmapped address 42 (watermark ends at 41).
    apb_rd(21'd42, 16'h0, 16'h0, "read_unmapped");
    apb_wr(21'd42, 16'h1);
    apb_rd(21'd0, 16'hE, 16'hE, "status_unmapped_err");
    apb_wr(21'd0, 16'h2);

    // Np=200: index 16384 overflows the buffer; done flags were cleared.
    apb_wr(21'd2, 16'd200);
    chk("np_200", 32'(p1[1]), 32'd200);
    apb_wr(21'(10 + 16384), 16'h77);
    apb_rd(21'd0, 16'h2, 16'h2, "status_overflow_err");
    apb_wr(21'd0, 16'h1);
    chk("overflow_no_pulse", 32'(sw1), 32'd0);

    // Re-arm with Np=4, then reset during the start write.
    apb_wr(21'd2, 16'd4);
    apb_wr(21'd25, 16'h11);
    apb_wr(21'd41, 16'h22);
    apb_wr(21'd0, 16'h2);
    apb_rd(21'd0, 16'hC, 16'hC, "status_rearmed");
    apb_wr(21'd0, 16'h1, 1'b0, 1'b1);
    chk("rst_cancel_pulse", 32'(sw1), 32'd0);
    chk("rst_cancel_busy", 32'(busy1), 32'd0);
    chk("rst_cancel_np", 32'(p1[1]), 32'd0);
    chk("rst_cancel_bmax", 32'(p1[8]), 32'd0);
    @(posedge clk); #1;
    chk("rst_cancel_pulse_late", 32'(sw1), 32'd0);
    apb_rd(21'd0, 16'h0, 16'h0, "status_after_midrst");

    repeat (3) @(posedge clk);
    #1;
    chk("apb_q_drained", 32'(apb_q.size()), 32'd0);
    chk("core_q_drained", 32'(core_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
